// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit processor.
// Issues one imem request at a time, buffers a returned word while decode stalls,
// and stops fetching once a HALT (opcode 00000) has been captured into IF/ID.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr_id,
    output logic [15:0] pc_inc_id,
    output logic        valid_id,
    output logic [4:0]  opcode_id,
    output logic        halted
);

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic        drop_q, drop_d;
    logic [15:0] instr_id_q, instr_id_d;
    logic [15:0] pc_inc_id_q, pc_inc_id_d;
    logic        valid_id_q, valid_id_d;

    logic [15:0] pc_plus2;
    logic        deliver;
    logic [15:0] deliver_word;

    assign pc_plus2 = pc_q + 16'd2;

    // Fetch control: PC, state, hold buffer and drop flag for a squashed in-flight request.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        drop_d       = drop_q;
        deliver      = 1'b0;
        deliver_word = hold_q;

        case (state_q)
            ST_ISSUE: begin
                if (flush) begin
                    pc_d = redirect_pc;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_done) begin
                    drop_d  = 1'b0;
                    state_d = ST_ISSUE;
                    if (flush) begin
                        pc_d = redirect_pc;
                    end else if (drop_q) begin
                        // Response belongs to a request squashed earlier; discard it.
                    end else if (!stall) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (flush) begin
                    // Request still outstanding: remember to drop its response.
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = redirect_pc;
                    state_d = ST_ISSUE;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_word = hold_q;
                end
            end
            ST_HALT: begin
                if (flush) begin
                    pc_d    = redirect_pc;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        // A word moving into IF/ID advances the PC and may stop fetch.
        if (deliver) begin
            pc_d    = pc_plus2;
            state_d = (deliver_word[15:11] == 5'd0) ? ST_HALT : ST_ISSUE;
        end
    end

    // IF/ID register update: flush beats stall, stall holds, otherwise new word or bubble.
    always_comb begin
        instr_id_d  = instr_id_q;
        pc_inc_id_d = pc_inc_id_q;
        valid_id_d  = valid_id_q;
        if (flush) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
        end else if (stall) begin
            instr_id_d  = instr_id_q;
        end else if (deliver) begin
            instr_id_d  = deliver_word;
            pc_inc_id_d = pc_plus2;
            valid_id_d  = 1'b1;
        end else begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ISSUE;
            pc_q        <= RESET_PC;
            hold_q      <= 16'h0000;
            drop_q      <= 1'b0;
            instr_id_q  <= NOP_INSTR;
            pc_inc_id_q <= 16'h0000;
            valid_id_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            drop_q      <= drop_d;
            instr_id_q  <= instr_id_d;
            pc_inc_id_q <= pc_inc_id_d;
            valid_id_q  <= valid_id_d;
        end
    end

    // Request is gated by rst so nothing leaves the stage while reset is held.
    always_comb begin
        imem_req  = rst && (state_q == ST_ISSUE) && !flush;
        imem_addr = pc_q;
        instr_id  = instr_id_q;
        pc_inc_id = pc_inc_id_q;
        valid_id  = valid_id_q;
        opcode_id = instr_id_q[15:11];
        halted    = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized
// stall/flush/latency traffic, all compared against a transaction-level model.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic [15:0] instr_id;
    logic [15:0] pc_inc_id;
    logic        valid_id;
    logic [4:0]  opcode_id;
    logic        halted;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .instr_id    (instr_id),
        .pc_inc_id   (pc_inc_id),
        .valid_id    (valid_id),
        .opcode_id   (opcode_id),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: one outstanding request, an optional held word, a halt flag.
    logic [15:0] m_pc;
    logic        m_busy;
    logic        m_drop;
    logic        m_buf_v;
    logic [15:0] m_buf;
    logic        m_halt;
    logic [15:0] m_instr;
    logic [15:0] m_pcinc;
    logic        m_valid;

    // Instruction memory: queued words first, random words otherwise.
    logic [15:0] word_q[$];
    int          mem_cnt;
    int          mem_lat;

    task automatic model_reset();
        m_pc = 16'h0000; m_busy = 0; m_drop = 0; m_buf_v = 0; m_buf = 0; m_halt = 0;
        m_instr = NOP; m_pcinc = 16'h0000; m_valid = 0;
        mem_cnt = 0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 15) == 0) w[15:11] = 5'd0;
        return w;
    endfunction

    task automatic model_step(input logic st, input logic fl, input logic [15:0] rpc,
                              input logic dn, input logic [15:0] wd);
        logic        got;
        logic [15:0] word;
        got = 0;
        word = 16'h0000;
        if (m_halt) begin
            if (fl) begin m_pc = rpc; m_halt = 0; end
        end else if (m_buf_v) begin
            if (fl) begin m_buf_v = 0; m_pc = rpc; end
            else if (!st) begin got = 1; word = m_buf; m_buf_v = 0; end
        end else if (m_busy) begin
            if (dn) begin
                m_busy = 0;
                if (fl) m_pc = rpc;
                else if (!m_drop) begin
                    if (st) begin m_buf_v = 1; m_buf = wd; end
                    else begin got = 1; word = wd; end
                end
                m_drop = 0;
            end else if (fl) begin
                m_pc = rpc; m_drop = 1;
            end
        end else begin
            if (fl) m_pc = rpc;
            else m_busy = 1;
        end
        if (fl) begin
            m_instr = NOP; m_valid = 0;
        end else if (!st) begin
            if (got) begin
                m_instr = word; m_pcinc = m_pc + 16'd2; m_valid = 1;
            end else begin
                m_instr = NOP; m_valid = 0;
            end
        end
        if (got) begin
            m_pc = m_pc + 16'd2;
            if (word[15:11] == 5'd0) m_halt = 1;
        end
    endtask

    task automatic check_outputs(input logic fl);
        logic m_req;
        m_req = !m_busy && !m_buf_v && !m_halt && !fl;
        check("imem_req",  {15'd0, imem_req}, {15'd0, m_req});
        check("imem_addr", imem_addr, m_pc);
        check("instr_id",  instr_id, m_instr);
        check("pc_inc_id", pc_inc_id, m_pcinc);
        check("valid_id",  {15'd0, valid_id}, {15'd0, m_valid});
        check("opcode_id", {11'd0, opcode_id}, {11'd0, m_instr[15:11]});
        check("halted",    {15'd0, halted}, {15'd0, m_halt});
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic run_cycle(input logic st, input logic fl, input logic [15:0] rpc,
                             input logic spur);
        logic        dn;
        logic [15:0] wd;
        logic        req_seen;
        dn = 0;
        wd = 16'($urandom);
        if (mem_cnt == 1) begin
            dn = 1;
            wd = (word_q.size() > 0) ? word_q.pop_front() : rand_word();
        end else if (spur && mem_cnt == 0 && !m_busy && !m_halt) begin
            dn = 1;  // response with no request outstanding; must be ignored
        end
        stall = st; flush = fl; redirect_pc = rpc; imem_done = dn; imem_rdata = wd;
        #1;
        check_outputs(fl);
        req_seen = imem_req;
        @(posedge clk);
        model_step(st, fl, rpc, dn, wd);
        if (mem_cnt > 0) mem_cnt--;
        if (req_seen) mem_cnt = mem_lat;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 16'h0000, 0);
    endtask

    initial begin
        rst = 0; stall = 0; flush = 0; redirect_pc = 0; imem_done = 0; imem_rdata = 0;
        mem_lat = 1;
        model_reset();
        @(negedge clk); #1;
        check("rst_req",   {15'd0, imem_req}, 16'd0);
        check("rst_instr", instr_id, NOP);
        check("rst_valid", {15'd0, valid_id}, 16'd0);
        check("rst_pcinc", pc_inc_id, 16'h0000);
        @(negedge clk);
        rst = 1;

        // Back-to-back fetches with single-cycle memory.
        word_q.push_back(16'h4021);
        word_q.push_back(16'h4822);
        idle(4);
        check("seq_instr", instr_id, 16'h4822);
        check("seq_pcinc", pc_inc_id, 16'h0004);

        // Stall across the response: word parks in the hold buffer.
        word_q.push_back(16'hC0FF);
        run_cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 1);
        run_cycle(0, 0, 0, 0);
        idle(1);

        // Flush while waiting, stale response arrives the next cycle.
        mem_lat = 2;
        word_q.push_back(16'h1234);
        run_cycle(0, 0, 0, 0);
        run_cycle(0, 1, 16'h0100, 0);
        run_cycle(0, 0, 0, 0);
        check("drop_addr", imem_addr, 16'h0100);
        mem_lat = 1;
        idle(2);

        // HALT capture, idle while halted, then redirect out.
        word_q.push_back(16'h0000);
        idle(2);
        idle(10);
        check("halt_flag", {15'd0, halted}, 16'd1);
        run_cycle(0, 1, 16'h0040, 0);
        idle(3);

        // PC wrap from 0xFFFE.
        run_cycle(0, 1, 16'hFFFE, 0);
        word_q.push_back(16'h5555);
        idle(3);

        // Asynchronous reset between edges while a request is outstanding.
        mem_lat = 3;
        idle(2);
        #2 rst = 0;
        #1;
        check("arst_valid", {15'd0, valid_id}, 16'd0);
        check("arst_instr", instr_id, NOP);
        check("arst_req",   {15'd0, imem_req}, 16'd0);
        check("arst_addr",  imem_addr, 16'h0000);
        @(negedge clk);
        rst = 1;
        model_reset();
        word_q.delete();
        mem_lat = 1;
        run_cycle(0, 0, 0, 1);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl, sp;
            logic [15:0] rpc;
            mem_lat = $urandom_range(1, 3);
            st  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 9) == 0);
            sp  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            run_cycle(st, fl, rpc, sp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
